// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable controller: FSM state encoding and width.
package cpu_clk_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } cpu_clk_state_e;

endpackage

// File: rtl/cpu_clk_ctrl_sync_edge.sv
// N-stage synchronizer for an asynchronous level, with an optional
// one-cycle rising-edge pulse taken from the synchronized output.
module sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) prev_q <= 1'b0;
                else       prev_q <= sync_q[STAGES-1];
            end
            assign rise_o = sync_q[STAGES-1] & ~prev_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: free-run / single-step / halt FSM gating tick edges
// into one-cycle cpu_en pulses. Define CPU_CLK_CTRL_CYCLE_COUNT_EN to add cycle_cnt.
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic               cpu_halt,
    output logic               cpu_en,
    output logic [STATE_W-1:0] state_o,
    output logic               halted
`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt
`endif
);

    cpu_clk_state_e state_q, state_d;
    logic           cpu_en_q, cpu_en_d;
    logic           tick_q;
    logic           tick_rise;
    logic           run_sync, run_rise_unused;
    logic           step_sync, step_rise;

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_run_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (run_sw),
        .q_o    (run_sync),
        .rise_o (run_rise_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_step_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (step_btn),
        .q_o    (step_sync),
        .rise_o (step_rise)
    );

    assign tick_rise = tick & ~tick_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cpu_en_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            tick_q   <= tick;
        end
    end

    // Halt outranks both the run switch and a coincident tick edge.
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run_sync)       state_d = ST_RUN;
                else if (step_rise) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (cpu_halt)       state_d = ST_HALTED;
                else if (!run_sync) state_d = ST_IDLE;
                else if (tick_rise) cpu_en_d = 1'b1;
            end
            ST_STEP: begin
                if (cpu_halt) begin
                    state_d = ST_HALTED;
                end else if (tick_rise) begin
                    cpu_en_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (!run_sync && !step_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu_en  = cpu_en_q;
    assign state_o = state_q;
    assign halted  = (state_q == ST_HALTED);

`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         cnt_q <= '0;
        else if (cpu_en_q) cnt_q <= cnt_q + 1'b1;
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: a vector table for the FSM walk plus
// hand sequences for run/step/drop/wrap/reset corners.
module tb_cpu_clk_ctrl;

    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       run_sw = 1'b0;
    logic       step_btn = 1'b0;
    logic       cpu_halt = 1'b0;
    logic       cpu_en;
    logic [1:0] state_o;
    logic       halted;
`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_cnt;
`endif

    cpu_clk_ctrl #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .cpu_halt (cpu_halt),
        .cpu_en   (cpu_en),
        .state_o  (state_o),
        .halted   (halted)
`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_HALT = 2'd3;

    int total  = 0;
    int passed = 0;
    int pulses = 0;
    int run_len = 0;
    int maxw   = 0;
    logic en_prev = 1'b0;

    // Counts cpu_en pulses and tracks the widest pulse seen.
    always @(negedge clk) begin
        if (cpu_en && !en_prev) pulses = pulses + 1;
        if (cpu_en) run_len = run_len + 1;
        else        run_len = 0;
        if (run_len > maxw) maxw = run_len;
        en_prev = cpu_en;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic clkn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0; run_sw = 1'b0; step_btn = 1'b0; cpu_halt = 1'b0;
        clkn(2);
        chk("rst state", {30'd0, state_o}, S_IDLE);
        chk("rst cpu_en", {31'd0, cpu_en}, 0);
        chk("rst halted", {31'd0, halted}, 0);
`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
        chk("rst cycle_cnt", {28'd0, cycle_cnt}, 0);
`endif
        reset = 1'b0;
        clkn(1);
    endtask

    task automatic tick_cycle();
        tick = 1'b1; clkn(12);
        tick = 1'b0; clkn(12);
    endtask

    typedef struct {
        logic       run, step, halt, tk;
        int         n;
        logic [1:0] st;
        logic       en, hl;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int p0;
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, S_IDLE, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, S_RUN,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, S_RUN,  1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, S_RUN,  1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, S_RUN,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, S_RUN,  1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, S_RUN,  1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, S_RUN,  1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, S_RUN,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1, S_HALT, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, S_HALT, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, S_HALT, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, S_HALT, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, S_IDLE, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, S_IDLE, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, S_IDLE, 1'b0, 1'b0};

        @(negedge clk);
        do_reset();

        foreach (vecs[i]) begin
            run_sw = vecs[i].run; step_btn = vecs[i].step;
            cpu_halt = vecs[i].halt; tick = vecs[i].tk;
            clkn(vecs[i].n);
            chk($sformatf("vec%0d state", i), {30'd0, state_o}, {30'd0, vecs[i].st});
            chk($sformatf("vec%0d cpu_en", i), {31'd0, cpu_en}, {31'd0, vecs[i].en});
            chk($sformatf("vec%0d halted", i), {31'd0, halted}, {31'd0, vecs[i].hl});
        end

        // Free run: five tick edges, five single-cycle pulses.
        do_reset();
        run_sw = 1'b1; clkn(4);
        chk("run state", {30'd0, state_o}, S_RUN);
        p0 = pulses; maxw = 0;
        repeat (5) tick_cycle();
        chk("run pulses", pulses - p0, 5);
        chk("run pulse width", maxw, 1);
`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
        chk("run cycle_cnt", {28'd0, cycle_cnt}, 5);
`endif

        // Single step, with a second press while already in STEP.
        do_reset();
        step_btn = 1'b1; clkn(3);
        chk("step entry", {30'd0, state_o}, S_STEP);
        step_btn = 1'b0; clkn(4);
        step_btn = 1'b1; clkn(4);
        step_btn = 1'b0; clkn(4);
        chk("step 2nd press", {30'd0, state_o}, S_STEP);
        p0 = pulses;
        tick_cycle();
        chk("step pulses", pulses - p0, 1);
        chk("step exit", {30'd0, state_o}, S_IDLE);
        tick_cycle();
        chk("step not queued", pulses - p0, 1);

        // run_sync falls on the same cycle as a tick edge.
        do_reset();
        run_sw = 1'b1; clkn(4);
        p0 = pulses;
        run_sw = 1'b0; clkn(2);
        tick = 1'b1; clkn(1);
        chk("drop state", {30'd0, state_o}, S_IDLE);
        chk("drop cpu_en", {31'd0, cpu_en}, 0);
        tick = 1'b0; clkn(3);
        chk("drop pulses", pulses - p0, 0);

        // Seventeen pulses through a 4-bit counter.
        do_reset();
        run_sw = 1'b1; clkn(4);
        p0 = pulses;
        repeat (17) tick_cycle();
        chk("wrap pulses", pulses - p0, 17);
`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
        chk("wrap cycle_cnt", {28'd0, cycle_cnt}, 1);
`endif

        // Reset lands while a pulse is in flight.
        tick = 1'b1;
        @(posedge clk); #1;
        chk("inflight cpu_en", {31'd0, cpu_en}, 1);
        reset = 1'b1; #1;
        chk("async rst cpu_en", {31'd0, cpu_en}, 0);
        chk("async rst state", {30'd0, state_o}, S_IDLE);
        chk("async rst halted", {31'd0, halted}, 0);
`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
        chk("async rst cycle_cnt", {28'd0, cycle_cnt}, 0);
`endif
        @(negedge clk);
        tick = 1'b0; run_sw = 1'b0;
        reset = 1'b0;
        clkn(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
